// File: rtl/ms_timeout_timer.sv
// Millisecond timeout engine: turns ms_clk rising edges into sb_clk-domain ticks
// and counts them against a selectable limit, pulsing timeout on expiry.
`timescale 1ns/1ps

module ms_timeout_timer #(
    parameter int unsigned COUNT_W = 10,
    parameter int unsigned LIMIT0  = 3,
    parameter int unsigned LIMIT1  = 12,
    parameter int unsigned LIMIT2  = 500,
    parameter int unsigned LIMIT3  = 1000
) (
    input  logic               sb_clk,
    input  logic               rst,
    input  logic               ms_clk,
    input  logic               timer_start,
    input  logic               timer_stop,
    input  logic [1:0]         timer_sel,
    output logic               timer_busy,
    output logic               timeout,
    output logic [COUNT_W-1:0] elapsed
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_nxt;
    logic               ms_q;
    logic [COUNT_W-1:0] limit_q;
    logic [COUNT_W-1:0] limit_nxt;
    logic [COUNT_W-1:0] elapsed_nxt;
    logic               busy_nxt;
    logic               timeout_nxt;

    logic               tick_c;
    logic [COUNT_W:0]   elapsed_inc_c;
    logic [COUNT_W-1:0] sel_limit_c;

    // ms_clk is slow and divider-derived, so it is treated as plain data here
    assign tick_c        = ms_clk & ~ms_q;
    assign elapsed_inc_c = {1'b0, elapsed} + (COUNT_W+1)'(1);

    // Limit table, truncated to the counter width
    always_comb begin
        sel_limit_c = COUNT_W'(LIMIT0);
        case (timer_sel)
            2'd0: sel_limit_c = COUNT_W'(LIMIT0);
            2'd1: sel_limit_c = COUNT_W'(LIMIT1);
            2'd2: sel_limit_c = COUNT_W'(LIMIT2);
            2'd3: sel_limit_c = COUNT_W'(LIMIT3);
            default: sel_limit_c = COUNT_W'(LIMIT0);
        endcase
    end

    // Next-state and output logic; start beats stop beats tick
    always_comb begin
        state_nxt   = state_q;
        limit_nxt   = limit_q;
        elapsed_nxt = elapsed;
        busy_nxt    = timer_busy;
        timeout_nxt = 1'b0;

        case (state_q)
            IDLE: begin
                if (timer_start) begin
                    limit_nxt   = sel_limit_c;
                    elapsed_nxt = '0;
                    busy_nxt    = 1'b1;
                    state_nxt   = RUN;
                end
            end
            RUN: begin
                if (timer_start) begin
                    limit_nxt   = sel_limit_c;
                    elapsed_nxt = '0;
                    busy_nxt    = 1'b1;
                end else if (timer_stop) begin
                    busy_nxt    = 1'b0;
                    state_nxt   = IDLE;
                end else if (tick_c) begin
                    // >= also covers a zero limit, which expires on the first tick
                    if (elapsed_inc_c >= {1'b0, limit_q}) begin
                        elapsed_nxt = limit_q;
                        timeout_nxt = 1'b1;
                        busy_nxt    = 1'b0;
                        state_nxt   = IDLE;
                    end else begin
                        elapsed_nxt = elapsed_inc_c[COUNT_W-1:0];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ms_q       <= 1'b0;
            limit_q    <= '0;
            elapsed    <= '0;
            timer_busy <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            ms_q       <= ms_clk;
            limit_q    <= limit_nxt;
            elapsed    <= elapsed_nxt;
            timer_busy <= busy_nxt;
            timeout    <= timeout_nxt;
        end
    end

endmodule
